// File: rtl/ram_copy_engine_if.sv
// Command and RAM-port bundle for ram_copy_engine.
// The slave side is the engine; the master side is the controller plus the RAM.
interface ram_copy_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  START_I;
    logic                  MODE_I;
    logic [ADDR_WIDTH-1:0] SRC_I;
    logic [ADDR_WIDTH-1:0] DST_I;
    logic [ADDR_WIDTH:0]   LEN_I;
    logic [DATA_WIDTH-1:0] FILL_I;
    logic                  BUSY_O;
    logic                  DONE_O;
    logic [ADDR_WIDTH:0]   COUNT_O;
    logic                  RAM_WE_O;
    logic [ADDR_WIDTH-1:0] RAM_ADDR_O;
    logic [DATA_WIDTH-1:0] RAM_DATA_O;
    logic [DATA_WIDTH-1:0] RAM_DATA_I;

    modport master (
        output START_I, MODE_I, SRC_I, DST_I, LEN_I, FILL_I, RAM_DATA_I,
        input  BUSY_O, DONE_O, COUNT_O, RAM_WE_O, RAM_ADDR_O, RAM_DATA_O
    );

    modport slave (
        input  START_I, MODE_I, SRC_I, DST_I, LEN_I, FILL_I, RAM_DATA_I,
        output BUSY_O, DONE_O, COUNT_O, RAM_WE_O, RAM_ADDR_O, RAM_DATA_O
    );
endinterface

// File: rtl/ram_copy_engine.sv
// Block copy / constant fill engine driving a single-port RAM whose read
// data appears the cycle after the address (copy = 2 cycles/word, fill = 1).
module ram_copy_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 CLK_I,
    input  logic                 RSTN_I,
    ram_copy_engine_if.slave     bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [ADDR_WIDTH:0]   len_eff;

    // A block can never exceed the RAM depth; longer requests are clipped.
    assign len_eff = (bus.LEN_I > DEPTH) ? DEPTH : bus.LEN_I;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        count_d = count_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START_I) begin
                    src_d   = bus.SRC_I;
                    dst_d   = bus.DST_I;
                    rem_d   = len_eff;
                    fill_d  = bus.FILL_I;
                    count_d = '0;
                    if (len_eff == '0)
                        state_d = ST_FIN;
                    else
                        state_d = bus.MODE_I ? ST_FILL : ST_RD;
                end
            end
            ST_RD: state_d = ST_WR;
            ST_WR: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                count_d = count_q + 1'b1;
                state_d = (rem_q == 1) ? ST_FIN : ST_RD;
            end
            ST_FILL: begin
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                count_d = count_q + 1'b1;
                state_d = (rem_q == 1) ? ST_FIN : ST_FILL;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    // RAM strobes decode from state only, so an asynchronous reset kills a write at once.
    always_comb begin
        bus.RAM_WE_O   = 1'b0;
        bus.RAM_ADDR_O = '0;
        bus.RAM_DATA_O = '0;
        case (state_q)
            ST_RD: begin
                bus.RAM_ADDR_O = src_q;
            end
            ST_WR: begin
                bus.RAM_WE_O   = 1'b1;
                bus.RAM_ADDR_O = dst_q;
                bus.RAM_DATA_O = bus.RAM_DATA_I;
            end
            ST_FILL: begin
                bus.RAM_WE_O   = 1'b1;
                bus.RAM_ADDR_O = dst_q;
                bus.RAM_DATA_O = fill_q;
            end
            default: begin
                bus.RAM_WE_O   = 1'b0;
            end
        endcase
    end

    assign bus.BUSY_O  = (state_q != ST_IDLE);
    assign bus.DONE_O  = (state_q == ST_FIN);
    assign bus.COUNT_O = count_q;
endmodule

// File: tb/tb_ram_copy_engine.sv
// Randomized self-checking bench for ram_copy_engine with a behavioural RAM
// and a word-level reference model of copy/fill results, latency and WE activity.
module tb_ram_copy_engine;
    logic clk;
    logic rstn;

    ram_copy_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    ram_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .CLK_I  (clk),
        .RSTN_I (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read address.
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] raddr_q;
    logic       bk_we;
    logic [7:0] bk_addr;
    logic [7:0] bk_data;

    always @(posedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (bus.RAM_WE_O)
            mem[bus.RAM_ADDR_O] <= bus.RAM_DATA_O;
        raddr_q <= bus.RAM_ADDR_O;
    end
    assign bus.RAM_DATA_I = mem[raddr_q];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
        exp_mem[a] = d;
    endtask

    // Reference: ascending word-by-word, so overlapping copies see earlier writes.
    task automatic model_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                             input int n, input logic [7:0] f);
        logic [7:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            exp_mem[da] = m ? f : exp_mem[sa];
        end
    endtask

    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [8:0] len, input logic [7:0] f, input bit inject);
        int n, k, lat, we_cnt, we_bad, exp_lat;
        bit exp_we;
        n = (len > 9'd256) ? 256 : int'(len);
        exp_lat = m ? n + 1 : 2 * n + 1;
        @(negedge clk);
        bus.MODE_I = m; bus.SRC_I = s; bus.DST_I = d; bus.LEN_I = len; bus.FILL_I = f;
        bus.START_I = 1'b1;
        @(posedge clk); #1;
        bus.START_I = 1'b0;
        model_cmd(m, s, d, n, f);
        check_eq("busy_rise", bus.BUSY_O, 1);
        k = 1; lat = 0; we_cnt = 0; we_bad = 0;
        while (k <= 2000) begin
            if (bus.RAM_WE_O) we_cnt++;
            exp_we = m ? (k <= n) : ((k <= 2 * n) && (k % 2 == 0));
            if (bus.RAM_WE_O !== exp_we) we_bad++;
            if (bus.DONE_O) begin
                lat = k;
                break;
            end
            if (inject && k == 1) begin
                bus.MODE_I = 1'($urandom_range(0, 1));
                bus.SRC_I  = 8'($urandom);
                bus.DST_I  = 8'($urandom);
                bus.LEN_I  = 9'($urandom_range(1, 40));
                bus.FILL_I = 8'($urandom);
                bus.START_I = 1'b1;
            end else if (k == 2) begin
                bus.START_I = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.START_I = 1'b0;
        check_eq("done_latency", lat, exp_lat);
        check_eq("we_pulses", we_cnt, n);
        check_eq("we_pattern", we_bad, 0);
        check_eq("count_final", bus.COUNT_O, n);
        @(posedge clk); #1;
        check_eq("done_one_cycle", bus.DONE_O, 0);
        check_eq("busy_fall", bus.BUSY_O, 0);
        check_eq("count_hold", bus.COUNT_O, n);
        check_eq("mem_diffs", mem_diffs(), 0);
        $display("[TB] cmd mode=%0d src=%02h dst=%02h len=%0d fill=%02h inject=%0d latency=%0d count=%0d",
                 m, s, d, len, f, inject, lat, bus.COUNT_O);
    endtask

    initial begin
        rstn = 1'b0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        bus.START_I = 1'b0; bus.MODE_I = 1'b0; bus.SRC_I = '0; bus.DST_I = '0;
        bus.LEN_I = '0; bus.FILL_I = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus.BUSY_O, 0);
        check_eq("rst_done", bus.DONE_O, 0);
        check_eq("rst_count", bus.COUNT_O, 0);
        check_eq("rst_we", bus.RAM_WE_O, 0);
        check_eq("rst_addr", bus.RAM_ADDR_O, 0);
        check_eq("rst_data", bus.RAM_DATA_O, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

        // Directed cases.
        run_cmd(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 1'b0);
        poke(8'h00, 8'h01); poke(8'h01, 8'h02); poke(8'h02, 8'h03);
        run_cmd(1'b0, 8'h00, 8'h80, 9'd3, 8'h00, 1'b0);
        check_eq("copy_82", mem[8'h82], 8'h03);
        run_cmd(1'b1, 8'h00, 8'hFE, 9'd3, 8'h3C, 1'b0);
        check_eq("wrap_00", mem[8'h00], 8'h3C);
        run_cmd(1'b1, 8'h00, 8'h40, 9'd0, 8'h77, 1'b0);
        run_cmd(1'b0, 8'h10, 8'h40, 9'd0, 8'h00, 1'b0);
        poke(8'h20, 8'h11); poke(8'h21, 8'h22); poke(8'h22, 8'h33);
        run_cmd(1'b0, 8'h20, 8'h21, 9'd2, 8'h00, 1'b0);
        check_eq("overlap_22", mem[8'h22], 8'h11);
        run_cmd(1'b0, 8'h30, 8'h30, 9'd5, 8'h00, 1'b0);
        run_cmd(1'b0, 8'h50, 8'h90, 9'd6, 8'h00, 1'b1);

        // Asynchronous reset while the fill presents dst 0x12.
        @(negedge clk);
        bus.MODE_I = 1'b1; bus.DST_I = 8'h10; bus.LEN_I = 9'd8; bus.FILL_I = 8'h5A;
        bus.START_I = 1'b1;
        @(posedge clk); #1;
        bus.START_I = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_eq("midfill_addr", bus.RAM_ADDR_O, 8'h12);
        rstn = 1'b0;
        #1;
        check_eq("midfill_we", bus.RAM_WE_O, 0);
        check_eq("midfill_busy", bus.BUSY_O, 0);
        check_eq("midfill_count", bus.COUNT_O, 0);
        check_eq("midfill_addr0", bus.RAM_ADDR_O, 0);
        exp_mem[8'h10] = 8'h5A;
        exp_mem[8'h11] = 8'h5A;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_eq("midfill_idle", bus.BUSY_O, 0);
        check_eq("midfill_mem", mem_diffs(), 0);
        $display("[TB] cmd reset-mid-fill dst=10 len=8 fill=5a busy=%0d", bus.BUSY_O);

        // Randomized commands, including oversized lengths and START while busy.
        for (int i = 0; i < 24; i++) begin
            logic [8:0] len;
            if (i == 5)       len = 9'd300;
            else if (i == 11) len = 9'd256;
            else              len = 9'($urandom_range(0, 24));
            run_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), len,
                    8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
